// File: rtl/flowid_alloc_ctrl.sv
// flowid_alloc_ctrl: connection-lifetime controller behind the flow ID manager.
//
// It handles one new-connection or close request at a time.
// - New connection: takes a free flow ID from the manager, stores the
//   connection tuple in table[id], sets the entry's valid bit and returns
//   the ID to the requester.
// - Close: clears the valid bit, hands the ID back to the manager and
//   reports the result to the requester.
// A combinational read port gives the stored tuple and valid bit of any entry.
//
// Optional feature: define FLOWID_DOUBLE_FREE_CHK_EN to reject closes of
// entries that are not valid. A rejected close returns nothing to the
// manager and responds with close_resp_ok=0. When the macro is undefined,
// every close frees its ID and close_resp_ok is tied to 1.
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   new_flow_*               new-connection request and response
//   close_*                  close request and response
//   flowid_req/avail/flowid  pop port of the manager's free-ID FIFO
//   flowid_ret_*             ID return port toward the manager
//   rd_flowid/rd_tuple/rd_valid  combinational table read port
//
// Handshake rule for every val/rdy pair: a transfer happens in a cycle where
// both val and rdy are 1. A producer holding val high keeps its payload
// stable until that cycle.
//
// The current FSM state is held in state_q, which has type tcp_pkg::flowid_state_e.

package tcp_pkg;
  localparam int FLOWID_W = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ALLOC_RESP = 2'd1,
    CLOSE_RET  = 2'd2,
    CLOSE_RESP = 2'd3
  } flowid_state_e;
endpackage

module flowid_alloc_ctrl
  import tcp_pkg::*;
#(
  parameter int TUPLE_W = 96
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                new_flow_val,
  input  logic [TUPLE_W-1:0]  new_flow_tuple,
  output logic                new_flow_rdy,
  output logic                new_flow_resp_val,
  output logic [FLOWID_W-1:0] new_flow_resp_flowid,
  input  logic                new_flow_resp_rdy,
  input  logic                close_val,
  input  logic [FLOWID_W-1:0] close_flowid,
  output logic                close_rdy,
  output logic                close_resp_val,
  output logic                close_resp_ok,
  input  logic                close_resp_rdy,
  output logic                flowid_req,
  input  logic                flowid_avail,
  input  logic [FLOWID_W-1:0] flowid,
  output logic                flowid_ret_val,
  output logic [FLOWID_W-1:0] flowid_ret_id,
  input  logic                flowid_ret_rdy,
  input  logic [FLOWID_W-1:0] rd_flowid,
  output logic [TUPLE_W-1:0]  rd_tuple,
  output logic                rd_valid
);

  localparam int DEPTH = 2 ** FLOWID_W;

  flowid_state_e       state_q, state_d;
  logic [FLOWID_W-1:0] id_q, id_d;
  logic [DEPTH-1:0]    valid_q;
  logic [TUPLE_W-1:0]  tuple_mem [DEPTH];
  logic                alloc_acc;
  logic                close_acc;
  logic                clr_valid;
`ifdef FLOWID_DOUBLE_FREE_CHK_EN
  logic                ok_q, ok_d;
`endif

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    alloc_acc = 1'b0;
    close_acc = 1'b0;
    clr_valid = 1'b0;
`ifdef FLOWID_DOUBLE_FREE_CHK_EN
    ok_d      = ok_q;
`endif
    case (state_q)
      IDLE: begin
        // Accepting nothing while rst is high keeps the manager FIFO from
        // being popped in a cycle that the reset will discard.
        if (!rst && close_val) begin
          close_acc = 1'b1;
          id_d      = close_flowid;
`ifdef FLOWID_DOUBLE_FREE_CHK_EN
          if (valid_q[close_flowid]) begin
            clr_valid = 1'b1;
            state_d   = CLOSE_RET;
          end else begin
            ok_d      = 1'b0;
            state_d   = CLOSE_RESP;
          end
`else
          clr_valid = 1'b1;
          state_d   = CLOSE_RET;
`endif
        end else if (!rst && new_flow_val && flowid_avail) begin
          alloc_acc = 1'b1;
          id_d      = flowid;
          state_d   = ALLOC_RESP;
        end
      end
      ALLOC_RESP: begin
        if (new_flow_resp_rdy) state_d = IDLE;
      end
      CLOSE_RET: begin
        if (flowid_ret_rdy) begin
`ifdef FLOWID_DOUBLE_FREE_CHK_EN
          ok_d = 1'b1;
`endif
          state_d = CLOSE_RESP;
        end
      end
      CLOSE_RESP: begin
        if (close_resp_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      valid_q <= '0;
`ifdef FLOWID_DOUBLE_FREE_CHK_EN
      ok_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
`ifdef FLOWID_DOUBLE_FREE_CHK_EN
      ok_q    <= ok_d;
`endif
      if (alloc_acc) valid_q[flowid] <= 1'b1;
      if (clr_valid) valid_q[close_flowid] <= 1'b0;
    end
  end

  // The tuple storage has no reset. An entry is only read as meaningful
  // when its valid bit is set.
  always_ff @(posedge clk) begin
    if (alloc_acc) tuple_mem[flowid] <= new_flow_tuple;
  end

  // A single latched ID serves both paths. Only one transaction is in flight,
  // so the allocated ID and the ID being returned never coexist.
  assign new_flow_rdy         = alloc_acc;
  assign flowid_req           = alloc_acc;
  assign close_rdy            = close_acc;
  assign new_flow_resp_val    = (state_q == ALLOC_RESP);
  assign new_flow_resp_flowid = id_q;
  assign flowid_ret_val       = (state_q == CLOSE_RET);
  assign flowid_ret_id        = id_q;
  assign close_resp_val       = (state_q == CLOSE_RESP);
`ifdef FLOWID_DOUBLE_FREE_CHK_EN
  assign close_resp_ok        = ok_q;
`else
  assign close_resp_ok        = 1'b1;
`endif

  assign rd_tuple = tuple_mem[rd_flowid];
  assign rd_valid = valid_q[rd_flowid];

endmodule

// File: tb/tb_flowid_alloc_ctrl.sv
// Directed testbench for flowid_alloc_ctrl.
// Inputs change 1 ns after a rising edge. Outputs are checked 1 ns later,
// which is well before the next rising edge.
module tb_flowid_alloc_ctrl;
  localparam int TW = 96;
  localparam int FW = tcp_pkg::FLOWID_W;
  localparam int DEPTH = 2 ** FW;
`ifdef FLOWID_DOUBLE_FREE_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          new_flow_val;
  logic [TW-1:0] new_flow_tuple;
  logic          new_flow_rdy;
  logic          new_flow_resp_val;
  logic [FW-1:0] new_flow_resp_flowid;
  logic          new_flow_resp_rdy;
  logic          close_val;
  logic [FW-1:0] close_flowid;
  logic          close_rdy;
  logic          close_resp_val;
  logic          close_resp_ok;
  logic          close_resp_rdy;
  logic          flowid_req;
  logic          flowid_avail;
  logic [FW-1:0] flowid;
  logic          flowid_ret_val;
  logic [FW-1:0] flowid_ret_id;
  logic          flowid_ret_rdy;
  logic [FW-1:0] rd_flowid;
  logic [TW-1:0] rd_tuple;
  logic          rd_valid;

  int checks = 0;
  int errors = 0;
  logic [FW-1:0] exp_q[$];

  flowid_alloc_ctrl #(.TUPLE_W(TW)) dut (
    .clk(clk), .rst(rst),
    .new_flow_val(new_flow_val), .new_flow_tuple(new_flow_tuple),
    .new_flow_rdy(new_flow_rdy), .new_flow_resp_val(new_flow_resp_val),
    .new_flow_resp_flowid(new_flow_resp_flowid), .new_flow_resp_rdy(new_flow_resp_rdy),
    .close_val(close_val), .close_flowid(close_flowid), .close_rdy(close_rdy),
    .close_resp_val(close_resp_val), .close_resp_ok(close_resp_ok),
    .close_resp_rdy(close_resp_rdy),
    .flowid_req(flowid_req), .flowid_avail(flowid_avail), .flowid(flowid),
    .flowid_ret_val(flowid_ret_val), .flowid_ret_id(flowid_ret_id),
    .flowid_ret_rdy(flowid_ret_rdy),
    .rd_flowid(rd_flowid), .rd_tuple(rd_tuple), .rd_valid(rd_valid)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_all_invalid(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      rd_flowid = FW'(i);
      #0.1;
      check(tag, rd_valid, 1'b0);
    end
  endtask

  // One allocation: accept now, response on the next cycle, immediate take.
  task automatic do_alloc(input logic [TW-1:0] t, input logic [FW-1:0] id);
    new_flow_val = 1'b1; new_flow_tuple = t; flowid_avail = 1'b1; flowid = id;
    rd_flowid = id;
    settle();
    check("alloc_rdy", new_flow_rdy, 1'b1);
    check("alloc_req", flowid_req, 1'b1);
    check("alloc_rd_old", rd_valid, 1'b0);
    exp_q.push_back(id);
    step();
    new_flow_val = 1'b0; flowid_avail = 1'b0;
    settle();
    check("alloc_resp_val", new_flow_resp_val, 1'b1);
    check("alloc_resp_id", new_flow_resp_flowid, exp_q.pop_front());
    check("alloc_rd_valid", rd_valid, 1'b1);
    check("alloc_rd_tuple", rd_tuple, t);
    new_flow_resp_rdy = 1'b1;
    step();
    new_flow_resp_rdy = 1'b0;
    settle();
    check("alloc_resp_drop", new_flow_resp_val, 1'b0);
  endtask

  // One close. exp_ret says whether the ID should go back to the manager.
  // The manager stalls the return for 'stall' cycles.
  task automatic do_close(input logic [FW-1:0] id, input int stall, input bit exp_ret);
    close_val = 1'b1; close_flowid = id; rd_flowid = id;
    settle();
    check("close_rdy", close_rdy, 1'b1);
    step();
    close_val = 1'b0;
    settle();
    if (exp_ret) begin
      for (int i = 0; i < stall; i++) begin
        check("ret_val_hold", flowid_ret_val, 1'b1);
        check("ret_id_hold", flowid_ret_id, id);
        check("close_resp_early", close_resp_val, 1'b0);
        step();
      end
      flowid_ret_rdy = 1'b1;
      settle();
      check("ret_val", flowid_ret_val, 1'b1);
      check("ret_id", flowid_ret_id, id);
      step();
      flowid_ret_rdy = 1'b0;
      settle();
    end else begin
      check("no_ret", flowid_ret_val, 1'b0);
    end
    check("close_resp_val", close_resp_val, 1'b1);
    check("close_resp_ok", close_resp_ok, exp_ret);
    check("close_rd_valid", rd_valid, 1'b0);
    close_resp_rdy = 1'b1;
    step();
    close_resp_rdy = 1'b0;
    settle();
    check("close_resp_drop", close_resp_val, 1'b0);
  endtask

  initial begin
    logic [TW-1:0] t0, t1, t2, t3, t4;
    t0 = {4'hA, 88'h0, 4'h1};
    t1 = 96'h0a00_0001_0a00_0002_1f90_0050;
    t2 = 96'hc0a8_0101_c0a8_0102_d431_01bb;
    t3 = 96'h1234_5678_9abc_def0_0bad_f00d;
    t4 = 96'hffff_0000_ffff_0000_aaaa_5555;

    // reset
    rst = 1'b1;
    new_flow_val = 1'b0; new_flow_tuple = '0; new_flow_resp_rdy = 1'b0;
    close_val = 1'b0; close_flowid = '0; close_resp_rdy = 1'b0;
    flowid_avail = 1'b0; flowid = '0; flowid_ret_rdy = 1'b0; rd_flowid = '0;
    step(); step();
    rst = 1'b0;
    settle();
    check("rst_new_rdy", new_flow_rdy, 1'b0);
    check("rst_req", flowid_req, 1'b0);
    check("rst_close_rdy", close_rdy, 1'b0);
    check("rst_resp_val", new_flow_resp_val, 1'b0);
    check("rst_close_resp_val", close_resp_val, 1'b0);
    check("rst_ret_val", flowid_ret_val, 1'b0);
    check("rst_resp_id", new_flow_resp_flowid, '0);
    check("rst_ret_id", flowid_ret_id, '0);
    check("rst_ok", close_resp_ok, CHK ? 1'b0 : 1'b1);
    check_all_invalid("rst_rd_valid");

    // first allocation: ID 0 with tuple 0xA..01
    step();
    do_alloc(t0, 4'd0);

    // request waits while the manager has no ID
    new_flow_val = 1'b1; new_flow_tuple = t1; flowid_avail = 1'b0; flowid = 4'd3;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("wait_rdy", new_flow_rdy, 1'b0);
      check("wait_req", flowid_req, 1'b0);
      step();
    end
    flowid_avail = 1'b1;
    settle();
    check("avail_rdy", new_flow_rdy, 1'b1);
    check("avail_req", flowid_req, 1'b1);
    exp_q.push_back(4'd3);
    step();
    new_flow_val = 1'b0; flowid_avail = 1'b0; rd_flowid = 4'd3;
    settle();
    check("avail_resp_val", new_flow_resp_val, 1'b1);
    check("avail_resp_id", new_flow_resp_flowid, exp_q.pop_front());
    check("avail_rd_tuple", rd_tuple, t1);
    new_flow_resp_rdy = 1'b1;
    step();
    new_flow_resp_rdy = 1'b0;

    // close ID 3 while the manager stalls the return for 4 cycles
    do_close(4'd3, 4, 1'b1);
    // second close of ID 3
    do_close(4'd3, 0, !CHK);

    // allocate ID 5, then a close and a new flow arrive in the same cycle
    do_alloc(t2, 4'd5);
    close_val = 1'b1; close_flowid = 4'd0;
    new_flow_val = 1'b1; new_flow_tuple = t3; flowid_avail = 1'b1; flowid = 4'd7;
    flowid_ret_rdy = 1'b1; close_resp_rdy = 1'b1;
    settle();
    check("prio_close_rdy", close_rdy, 1'b1);
    check("prio_new_rdy", new_flow_rdy, 1'b0);
    check("prio_req", flowid_req, 1'b0);
    step();
    close_val = 1'b0;
    settle();
    check("prio_ret_val", flowid_ret_val, 1'b1);
    check("prio_ret_id", flowid_ret_id, 4'd0);
    check("prio_new_rdy_ret", new_flow_rdy, 1'b0);
    step();
    check("prio_close_resp", close_resp_val, 1'b1);
    check("prio_new_rdy_resp", new_flow_rdy, 1'b0);
    step();
    check("prio_new_accept", new_flow_rdy, 1'b1);
    check("prio_new_req", flowid_req, 1'b1);
    exp_q.push_back(4'd7);
    step();
    new_flow_val = 1'b0; flowid_avail = 1'b0; flowid_ret_rdy = 1'b0; close_resp_rdy = 1'b0;
    settle();
    check("hold_val0", new_flow_resp_val, 1'b1);
    check("hold_id0", new_flow_resp_flowid, exp_q[0]);
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_val", new_flow_resp_val, 1'b1);
      check("hold_id", new_flow_resp_flowid, exp_q[0]);
    end
    void'(exp_q.pop_front());

    // reset during ALLOC_RESP aborts the transaction
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    check("abort_resp_val", new_flow_resp_val, 1'b0);
    check("abort_ret_val", flowid_ret_val, 1'b0);
    check("abort_close_resp_val", close_resp_val, 1'b0);
    check("abort_resp_id", new_flow_resp_flowid, '0);
    check_all_invalid("abort_rd_valid");

    // normal operation after the abort
    step();
    do_alloc(t4, 4'd9);
    do_close(4'd9, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/flowid_alloc_ctrl.md
# flowid_alloc_ctrl

Connection-lifetime controller sitting directly downstream of the flow ID manager in the TCP slow path. Serializes new-connection and close requests. Pulls a free flow ID from the manager per new connection, records the connection 4-tuple in a per-flow table with a valid bit, and returns the ID through the manager's return port on close. Provides a combinational tuple read port indexed by flow ID for later stages.

## Interface
- `TUPLE_W`, default 96: connection tuple width (src IP, dst IP, src port, dst port).
- `FLOWID_W`: flow ID width, taken from `tcp_pkg`; not overridable. The table has 2^FLOWID_W entries.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `new_flow_val` in 1: new-connection request valid.
- `new_flow_tuple` in TUPLE_W: tuple of the new connection.
- `new_flow_rdy` out 1: request accepted this cycle.
- `new_flow_resp_val` out 1: allocation result valid.
- `new_flow_resp_flowid` out FLOWID_W: allocated flow ID.
- `new_flow_resp_rdy` in 1: consumer takes the result.
- `close_val` in 1: close request valid.
- `close_flowid` in FLOWID_W: flow ID to free.
- `close_rdy` out 1: close request accepted this cycle.
- `close_resp_val` out 1: close result valid.
- `close_resp_ok` out 1: 1 means the ID was freed; 0 means the request was rejected (entry not valid).
- `close_resp_rdy` in 1: consumer takes the close result.
- `flowid_req` out 1: consume the ID offered by the manager.
- `flowid_avail` in 1: manager has an ID on `flowid`.
- `flowid` in FLOWID_W: ID offered by the manager.
- `flowid_ret_val` out 1: returning an ID to the manager.
- `flowid_ret_id` out FLOWID_W: ID being returned.
- `flowid_ret_rdy` in 1: manager accepts the return.
- `rd_flowid` in FLOWID_W: table read index.
- `rd_tuple` out TUPLE_W: stored tuple, combinational from `rd_flowid`.
- `rd_valid` out 1: valid bit of the entry, combinational from `rd_flowid`.

## Operation
- FSM states: IDLE, ALLOC_RESP, CLOSE_RET, CLOSE_RESP. One transaction is in flight at a time.
- **IDLE, close priority:** if `close_val`:
  - Assert `close_rdy` and latch `close_flowid`.
  - If the entry is valid: clear its valid bit and go to CLOSE_RET.
  - Otherwise: set ok=0 and go to CLOSE_RESP.
- **IDLE, allocation:** else if `new_flow_val & flowid_avail`:
  - Assert `new_flow_rdy` and `flowid_req` together.
  - Latch `flowid`, write `new_flow_tuple` to table[flowid], set its valid bit.
  - Go to ALLOC_RESP.
- `flowid_req` is asserted only in that IDLE allocation cycle, and never when `flowid_avail`=0. The manager's FIFO is never read while empty.
- `new_flow_val` with `flowid_avail`=0: `new_flow_rdy`=0; the request waits, with no timeout.
- **ALLOC_RESP:** `new_flow_resp_val`=1 with the latched ID, held until `new_flow_resp_rdy`, then go to IDLE.
- **CLOSE_RET:** `flowid_ret_val`=1, `flowid_ret_id`=latched ID, held until `flowid_ret_rdy`. Then set ok=1 and go to CLOSE_RESP.
- **CLOSE_RESP:** `close_resp_val`=1 with `close_resp_ok`, held until `close_resp_rdy`, then go to IDLE.
- All response outputs hold value while `val` is high and `rdy` is low.
- Duplicate tuples are not detected; that is the caller's responsibility.
- Reset values:
  - State IDLE; all valid bits 0.
  - All `*_val`, `*_rdy`, `flowid_req` outputs 0.
  - `new_flow_resp_flowid`, `flowid_ret_id`, `close_resp_ok` 0.
  - Tuple storage is not reset.
- Reset asserted mid-transaction aborts it, with no response or return issued. Upstream is reset together with this block.

## Timing
- Accept at cycle N → response `val` at N+1. Minimum allocation turnaround is 2 cycles (accept, respond). Next accept is possible at the cycle after the response handshake.
- Close of a valid entry: accept N, return at N+1 (stalls on `flowid_ret_rdy`), response at the cycle after the return handshake. Minimum 3 cycles.
- Table write and valid-bit updates take effect at the clock edge ending the accept cycle. `rd_tuple`/`rd_valid` reflect them from N+1.
- A read to the entry being written in cycle N returns the old contents in N.
- Simultaneous `close_val` and `new_flow_val` in IDLE: the close is served; the new flow waits.

## Configuration
- `FLOWID_DOUBLE_FREE_CHK_EN`:
  - Defined: the valid-bit check above applies, and closing an invalid entry gives `close_resp_ok`=0 with no return to the manager.
  - Undefined: every close clears the valid bit, goes to CLOSE_RET, and responds ok=1. `close_resp_ok` is tied 1.

## Test plan
- After reset, `rd_valid`=0 for all IDs. One new flow, tuple 0xA…01, manager offers ID 0 → `new_flow_resp_flowid`=0 at N+1; `rd_flowid`=0 gives `rd_tuple`=0xA…01, `rd_valid`=1.
- `flowid_avail`=0 for 5 cycles with `new_flow_val`=1 → `new_flow_rdy`=0 and `flowid_req`=0 throughout. Avail rises → accepted that cycle.
- Close ID 3 (valid), `flowid_ret_rdy` low for 4 cycles → `flowid_ret_val` held with ID 3, then `close_resp_ok`=1; `rd_valid`[3]=0.
- With `FLOWID_DOUBLE_FREE_CHK_EN`, close ID 3 twice → second gives `close_resp_ok`=0 and no `flowid_ret_val`. Without the macro, the second close returns ID 3 with ok=1.
- `close_val` and `new_flow_val` asserted in the same IDLE cycle → close accepted first; new flow accepted in the cycle after `close_resp` handshake.
- `new_flow_resp_rdy` held low 3 cycles → response and ID stable; `rst` during ALLOC_RESP → all `val` outputs 0 next cycle, all valid bits cleared.
